// File: rtl/repsub_divider.sv
// Sequential unsigned divider: quotient/remainder by repeated subtraction with start/done handshake.
// Optional divide-by-zero flag port enabled by defining REPSUB_DBZ_EN.
module repsub_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done
`ifdef REPSUB_DBZ_EN
  ,
  output logic         dbz
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t       state, state_next;
  logic [W-1:0] b, b_next;
  logic [W-1:0] quotient_next, remainder_next;
  logic         busy_next, done_next;
`ifdef REPSUB_DBZ_EN
  logic         dbz_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      b         <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REPSUB_DBZ_EN
      dbz       <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      b         <= b_next;
      quotient  <= quotient_next;
      remainder <= remainder_next;
      busy      <= busy_next;
      done      <= done_next;
`ifdef REPSUB_DBZ_EN
      dbz       <= dbz_next;
`endif
    end
  end

  always_comb begin
    state_next     = state;
    b_next         = b;
    quotient_next  = quotient;
    remainder_next = remainder;
    busy_next      = 1'b0;
    done_next      = 1'b0;
`ifdef REPSUB_DBZ_EN
    dbz_next       = dbz;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          b_next         = divisor;
          remainder_next = dividend;
          quotient_next  = '0;
`ifdef REPSUB_DBZ_EN
          dbz_next       = 1'b0;
`endif
          if (divisor == '0) begin
            // Zero divisor skips RUN entirely and reports at once.
            state_next    = DONE;
            done_next     = 1'b1;
`ifdef REPSUB_DBZ_EN
            dbz_next       = 1'b1;
            remainder_next = '0;
`else
            quotient_next  = '1;
`endif
          end else begin
            state_next = RUN;
            busy_next  = 1'b1;
          end
        end
      end
      RUN: begin
        if (remainder >= b) begin
          remainder_next = remainder - b;
          quotient_next  = quotient + 1'b1;
          busy_next      = 1'b1;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_repsub_divider.sv
// Scoreboard bench for repsub_divider: stimulus pushes expected results, a monitor checks each done pulse.
module tb_repsub_divider;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done;
`ifdef REPSUB_DBZ_EN
  logic         dbz;
`endif

  repsub_divider #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done)
`ifdef REPSUB_DBZ_EN
    ,
    .dbz(dbz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    bit           chk_lat;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef REPSUB_DBZ_EN
        check("dbz", 32'(dbz), 32'(e.z));
`endif
        if (e.chk_lat) check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        $display("done: q=%0d r=%0d at cycle %0d", quotient, remainder, cyc);
      end
    end
  end

  // Issue one division from a negedge; lat is the hand-computed Q+1 edges after accept.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic z, input bit chk_lat, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.chk_lat = chk_lat; e.done_cyc = cyc + 1 + lat;
    sb.push_back(e);
    dividend = a;
    divisor  = d;
    start    = 1'b1;
    $display("issue: %0d / %0d -> expect q=%0d r=%0d", a, d, q, r);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bc;
    repeat (2) @(negedge clk);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 23/5: busy for 5 cycles, result held afterwards.
    do_div(8'd23, 8'd5, 8'd4, 8'd3, 1'b0, 1'b1, 5);
    bc = int'(busy);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bc += int'(busy);
    end
    check("busy_cycles", 32'(bc), 32'd5);
    check("held_quotient", 32'(quotient), 32'd4);
    check("held_remainder", 32'(remainder), 32'd3);
    wait_empty(20);

    do_div(8'd7, 8'd9, 8'd0, 8'd7, 1'b0, 1'b1, 1);
    wait_empty(20);
    do_div(8'd9, 8'd9, 8'd1, 8'd0, 1'b0, 1'b1, 2);
    wait_empty(20);

    // 255/1 with start toggled and operands changed during RUN.
    do_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, 256);
    dividend = 8'd3;
    divisor  = 8'd2;
    for (int i = 0; i < 20; i++) begin
      start = ~start;
      @(negedge clk);
    end
    start = 1'b0;
    wait_empty(400);

    // Divide by zero: busy never rises.
`ifdef REPSUB_DBZ_EN
    do_div(8'd40, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 0);
`else
    do_div(8'd40, 8'd0, 8'd255, 8'd40, 1'b0, 1'b0, 0);
`endif
    bc = int'(busy);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bc += int'(busy);
    end
    check("dbz_busy_cycles", 32'(bc), 32'd0);
    wait_empty(20);

    // Asynchronous reset mid-RUN, then a clean rerun.
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idle_busy", 32'(busy), 32'd0);
    do_div(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b1, 67);
    wait_empty(200);

    // start held high: back-to-back 10/4 every 5 edges (one IDLE cycle between).
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.q = 8'd2; e.r = 8'd2; e.z = 1'b0; e.chk_lat = 1'b1;
      e.done_cyc = cyc + 1 + 3 + 5 * k;
      sb.push_back(e);
    end
    $display("issue: 10 / 4 x3 with start held -> expect q=2 r=2 each");
    dividend = 8'd10;
    divisor  = 8'd4;
    start    = 1'b1;
    repeat (11) @(negedge clk);
    start = 1'b0;
    wait_empty(40);
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t expected completion", $time);
    $fatal(1, "global timeout");
  end
endmodule
